// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ctrl_pkg
//  Purpose  : Shared types and defaults for the PUSH/POP stack sequencer.
//             Holds the FSM state encoding, the stack geometry defaults and
//             the PUSHi/POPi opcode values used by the decoder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package stack_ctrl_pkg;

  // Stack geometry defaults
  localparam int              DATA_W_DEF    = 16;
  localparam int              ADDR_W_DEF    = 16;
  localparam logic [15:0]     STK_TOP_DEF   = 16'hFFFF;
  localparam int              STK_DEPTH_DEF = 256;

  // Opcodes that the decoder turns into push_req / pop_req
  localparam logic [3:0]      OP_PUSHI      = 4'hC;
  localparam logic [3:0]      OP_POPI       = 4'hD;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_POP_RD  = 3'd2,
    ST_POP_WB  = 3'd3,
    ST_ERR     = 3'd4
  } stk_state_e;

endpackage : stack_ctrl_pkg
`default_nettype wire

// File: rtl/stack_ctrl_stk_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : stk_ptr
//  Purpose  : Stack pointer register. SP points at the next free slot and
//             the stack grows down from STK_TOP.
//  Ports    : clk, rst_n        clock / async active-low reset
//             inc, dec          SP+1 (pop) / SP-1 (push); inc has priority
//             sp                current stack pointer
//             full, empty       STK_TOP-SP == STK_DEPTH / SP == STK_TOP
//  Revision : 1.0  initial release
// ============================================================================
module stk_ptr #(
  parameter int               ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] STK_TOP  = '1,
  parameter int               STK_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty
);

  // Lowest value SP can hold; reaching it means every slot is occupied.
  localparam logic [ADDR_W-1:0] C_SP_BOTTOM = STK_TOP - ADDR_W'(STK_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= STK_TOP;
    end else if (inc) begin
      sp <= sp + ADDR_W'(1);
    end else if (dec) begin
      sp <= sp - ADDR_W'(1);
    end
  end

  assign full  = (sp == C_SP_BOTTOM);
  assign empty = (sp == STK_TOP);

endmodule : stk_ptr
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ctrl
//  Purpose  : Multi-cycle PUSH/POP sequencer. Owns SP, issues stack accesses
//             on the shared DM port (pipeline LW/SW win), stalls the front
//             end while an op is in flight and writes POP data to the RF.
//  Ports    : clk, rst_n            clock / async active-low reset
//             push_req, pop_req     1-cycle request pulses from ID
//             push_data             operand to push (with push_req)
//             pop_dst_addr          RF destination (with pop_req)
//             flush                 kills a same-cycle request
//             pipe_dm_busy          pipeline owns the DM port this cycle
//             dm_rd_data            DM read data, one cycle after stk_dm_re
//             stk_dm_addr/wdata/we/re   stack DM access
//             stk_rf_we/dst/wdata       POP write-back
//             stall_stk             front-end stall
//             sp                    current stack pointer
//             stk_ovfl, stk_unfl    sticky overflow / underflow flags
//  Revision : 1.0  initial release
// ============================================================================
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] STK_TOP   = STK_TOP_DEF,
  parameter int                STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic [3:0]        pop_dst_addr,
  input  logic              flush,
  input  logic              pipe_dm_busy,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic [ADDR_W-1:0] stk_dm_addr,
  output logic [DATA_W-1:0] stk_dm_wdata,
  output logic              stk_dm_we,
  output logic              stk_dm_re,
  output logic              stk_rf_we,
  output logic [3:0]        stk_rf_dst,
  output logic [DATA_W-1:0] stk_rf_wdata,
  output logic              stall_stk,
  output logic [ADDR_W-1:0] sp,
  output logic              stk_ovfl,
  output logic              stk_unfl
);

  stk_state_e        state, state_nxt;
  logic [DATA_W-1:0] push_data_q;
  logic [3:0]        pop_dst_q;
  logic              accept;
  logic              sp_inc, sp_dec;
  logic              cap_push, cap_pop;
  logic              set_ovfl, set_unfl;
  logic              full, empty;

  stk_ptr #(
    .ADDR_W    (ADDR_W),
    .STK_TOP   (STK_TOP),
    .STK_DEPTH (STK_DEPTH)
  ) u_stk_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  assign accept = (state == ST_IDLE) & (push_req | pop_req) & ~flush;

  // The front end must freeze in the very cycle a request is accepted,
  // otherwise the next instruction would slip past the sequencer.
  assign stall_stk = (state != ST_IDLE) | accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_data_q <= '0;
      pop_dst_q   <= '0;
      stk_ovfl    <= 1'b0;
      stk_unfl    <= 1'b0;
    end else begin
      if (cap_push) push_data_q <= push_data;
      if (cap_pop)  pop_dst_q   <= pop_dst_addr;
      if (set_ovfl) stk_ovfl    <= 1'b1;
      if (set_unfl) stk_unfl    <= 1'b1;
    end
  end

  // Next-state and SP control. A simultaneous PUSH and POP resolves to the
  // PUSH; the POP is dropped and never reported.
  always_comb begin
    state_nxt = state;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    cap_push  = 1'b0;
    cap_pop   = 1'b0;
    set_ovfl  = 1'b0;
    set_unfl  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (push_req) begin
            if (full) begin
              state_nxt = ST_ERR;
              set_ovfl  = 1'b1;
            end else begin
              state_nxt = ST_PUSH_WR;
              cap_push  = 1'b1;
            end
          end else if (empty) begin
            state_nxt = ST_ERR;
            set_unfl  = 1'b1;
          end else begin
            state_nxt = ST_POP_RD;
            cap_pop   = 1'b1;
          end
        end
      end
      ST_PUSH_WR: begin
        if (!pipe_dm_busy) begin
          sp_dec    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_POP_RD: begin
        if (!pipe_dm_busy) begin
          sp_inc    = 1'b1;
          state_nxt = ST_POP_WB;
        end
      end
      ST_POP_WB: state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Access decode. Address/data follow the state alone; the strobes are
  // additionally gated by pipe_dm_busy so the pipeline keeps the port.
  always_comb begin
    stk_dm_addr  = '0;
    stk_dm_wdata = '0;
    stk_dm_we    = 1'b0;
    stk_dm_re    = 1'b0;
    stk_rf_we    = 1'b0;
    stk_rf_dst   = '0;
    stk_rf_wdata = '0;
    case (state)
      ST_PUSH_WR: begin
        stk_dm_addr  = sp;
        stk_dm_wdata = push_data_q;
        stk_dm_we    = ~pipe_dm_busy;
      end
      ST_POP_RD: begin
        // SP names the next free slot, so the top entry sits one above it.
        stk_dm_addr = sp + ADDR_W'(1);
        stk_dm_re   = ~pipe_dm_busy;
      end
      ST_POP_WB: begin
        stk_rf_we    = 1'b1;
        stk_rf_dst   = pop_dst_q;
        stk_rf_wdata = dm_rd_data;
      end
      default: ;
    endcase
  end

endmodule : stack_ctrl
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_ctrl
//  Purpose  : Scoreboard bench for stack_ctrl. Stimulus pushes the expected
//             DM/RF events (kind, cycle, address, data, RF destination) into
//             a queue; a negedge monitor pops and compares each event the
//             DUT presents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stack_ctrl;

  typedef struct {
    logic [2:0]  kind;   // {we, re, rf_we}
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  dst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_req, pop_req, flush, pipe_dm_busy;
  logic [15:0] push_data, dm_rd_data;
  logic [3:0]  pop_dst_addr;
  logic [15:0] stk_dm_addr, stk_dm_wdata, stk_rf_wdata, sp;
  logic        stk_dm_we, stk_dm_re, stk_rf_we, stall_stk, stk_ovfl, stk_unfl;
  logic [3:0]  stk_rf_dst;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_sp = 16'hFFFF;

  stack_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_req     (push_req),
    .pop_req      (pop_req),
    .push_data    (push_data),
    .pop_dst_addr (pop_dst_addr),
    .flush        (flush),
    .pipe_dm_busy (pipe_dm_busy),
    .dm_rd_data   (dm_rd_data),
    .stk_dm_addr  (stk_dm_addr),
    .stk_dm_wdata (stk_dm_wdata),
    .stk_dm_we    (stk_dm_we),
    .stk_dm_re    (stk_dm_re),
    .stk_rf_we    (stk_rf_we),
    .stk_rf_dst   (stk_rf_dst),
    .stk_rf_wdata (stk_rf_wdata),
    .stall_stk    (stall_stk),
    .sp           (sp),
    .stk_ovfl     (stk_ovfl),
    .stk_unfl     (stk_unfl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (stk_dm_we || stk_dm_re || stk_rf_we)) begin
      chk("we_re_exclusive", {31'd0, stk_dm_we & stk_dm_re}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_strobe: got we=%b re=%b rf_we=%b expected none (cycle %0d)",
                 stk_dm_we, stk_dm_re, stk_rf_we, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind",  {29'd0, stk_dm_we, stk_dm_re, stk_rf_we}, {29'd0, e.kind});
        chk("event_cycle", cyc, e.cyc);
        if (e.kind == 3'b100) begin
          chk("wr_addr",  {16'd0, stk_dm_addr},  {16'd0, e.addr});
          chk("wr_data",  {16'd0, stk_dm_wdata}, {16'd0, e.data});
        end else if (e.kind == 3'b010) begin
          chk("rd_addr",  {16'd0, stk_dm_addr},  {16'd0, e.addr});
        end else begin
          chk("rf_dst",   {28'd0, stk_rf_dst},   {28'd0, e.dst});
          chk("rf_wdata", {16'd0, stk_rf_wdata}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(logic [2:0] k, int c, logic [15:0] a, logic [15:0] d, logic [3:0] r);
    exp_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d; e.dst = r;
    return e;
  endfunction

  // PUSH issued at t0 (now); write lands after busy_n hold cycles.
  task automatic do_push(input logic [15:0] d, input int busy_n, input logic with_pop);
    push_req = 1'b1; pop_req = with_pop; push_data = d; pop_dst_addr = 4'hF;
    sb.push_back(mk(3'b100, cyc + 1 + busy_n, exp_sp, d, 4'h0));
    #1 chk("push_stall_t0", {31'd0, stall_stk}, 32'd1);
    tick();
    push_req = 1'b0; pop_req = 1'b0; push_data = 16'h0000;
    for (int i = 0; i < busy_n; i++) begin
      pipe_dm_busy = 1'b1;
      #1 chk("push_hold_we", {31'd0, stk_dm_we}, 32'd0);
      chk("push_hold_sp", {16'd0, sp}, {16'd0, exp_sp});
      tick();
    end
    pipe_dm_busy = 1'b0;
    #1 chk("push_stall_t1", {31'd0, stall_stk}, 32'd1);
    tick();
    exp_sp = exp_sp - 16'd1;
    chk("push_stall_t2", {31'd0, stall_stk}, 32'd0);
    chk("push_sp", {16'd0, sp}, {16'd0, exp_sp});
  endtask

  // POP issued at t0; read at t1, RF write-back at t2.
  task automatic do_pop(input logic [3:0] dst, input logic [15:0] d);
    pop_req = 1'b1; pop_dst_addr = dst;
    sb.push_back(mk(3'b010, cyc + 1, exp_sp + 16'd1, 16'h0, 4'h0));
    sb.push_back(mk(3'b001, cyc + 2, 16'h0, d, dst));
    #1 chk("pop_stall_t0", {31'd0, stall_stk}, 32'd1);
    tick();
    pop_req = 1'b0; pop_dst_addr = 4'h0;
    tick();
    dm_rd_data = d;
    #1 chk("pop_stall_t2", {31'd0, stall_stk}, 32'd1);
    tick();
    dm_rd_data = 16'h0000;
    exp_sp = exp_sp + 16'd1;
    chk("pop_stall_t3", {31'd0, stall_stk}, 32'd0);
    chk("pop_sp", {16'd0, sp}, {16'd0, exp_sp});
  endtask

  initial begin
    rst_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; flush = 1'b0;
    pipe_dm_busy = 1'b0; push_data = 16'h0; dm_rd_data = 16'h0; pop_dst_addr = 4'h0;
    tick(); tick();
    chk("rst_sp",    {16'd0, sp}, 32'h0000FFFF);
    chk("rst_stall", {31'd0, stall_stk}, 32'd0);
    chk("rst_strb",  {29'd0, stk_dm_we, stk_dm_re, stk_rf_we}, 32'd0);
    chk("rst_flags", {30'd0, stk_ovfl, stk_unfl}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic PUSH / POP round trip, then a PUSH held off by the pipeline.
    do_push(16'hA5A5, 0, 1'b0);
    do_pop(4'd3, 16'hA5A5);
    do_push(16'h1234, 2, 1'b0);
    do_pop(4'd7, 16'h1234);

    // POP on an empty stack.
    pop_req = 1'b1; pop_dst_addr = 4'd2;
    #1 chk("unfl_stall_t0", {31'd0, stall_stk}, 32'd1);
    tick();
    pop_req = 1'b0;
    tick();
    chk("unfl_flag",  {31'd0, stk_unfl}, 32'd1);
    chk("unfl_sp",    {16'd0, sp}, 32'h0000FFFF);
    chk("unfl_stall", {31'd0, stall_stk}, 32'd0);

    // Flushed request is ignored.
    push_req = 1'b1; flush = 1'b1; push_data = 16'hDEAD;
    #1 chk("flush_stall", {31'd0, stall_stk}, 32'd0);
    tick();
    push_req = 1'b0; flush = 1'b0;
    tick();
    chk("flush_sp",    {16'd0, sp}, {16'd0, exp_sp});
    chk("flush_stall2", {31'd0, stall_stk}, 32'd0);

    // PUSH and POP together: only the PUSH runs.
    do_push(16'hBEEF, 0, 1'b1);

    // Fill to STK_DEPTH entries, then overflow once.
    while (exp_sp != 16'hFEFF) do_push(exp_sp ^ 16'h5A5A, 0, 1'b0);
    chk("full_sp", {16'd0, sp}, 32'h0000FEFF);
    chk("pre_ovfl_flag", {31'd0, stk_ovfl}, 32'd0);
    push_req = 1'b1; push_data = 16'hFFFF;
    tick();
    push_req = 1'b0;
    tick();
    chk("ovfl_flag", {31'd0, stk_ovfl}, 32'd1);
    chk("ovfl_sp",   {16'd0, sp}, 32'h0000FEFF);

    // Async reset while POP_RD drives the read strobe.
    pop_req = 1'b1; pop_dst_addr = 4'd5;
    tick();
    pop_req = 1'b0;
    chk("pre_rst_re", {31'd0, stk_dm_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strb",  {29'd0, stk_dm_we, stk_dm_re, stk_rf_we}, 32'd0);
    chk("mid_rst_sp",    {16'd0, sp}, 32'h0000FFFF);
    chk("mid_rst_stall", {31'd0, stall_stk}, 32'd0);
    chk("mid_rst_flags", {30'd0, stk_ovfl, stk_unfl}, 32'd0);
    tick();
    rst_n = 1'b1;
    exp_sp = 16'hFFFF;
    tick();
    chk("post_rst_stall", {31'd0, stall_stk}, 32'd0);
    do_push(16'h0F0F, 0, 1'b0);

    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_stack_ctrl
`default_nettype wire
